ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter STK_WIDTH, default 32, the return-address and stack data width.
REQ-002 SHALL have parameter PTR_WIDTH, default 6, matching the stack pointer width (2**PTR_WIDTH entries).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IS_CALL  input  1  decode-stage JAL/JALR valid this cycle.
REQ-006 SHALL have port IS_RET  input  1  decode-stage JR $ra valid this cycle.
REQ-007 SHALL have port PC_PLUS4  input  STK_WIDTH  return address of the call in decode.
REQ-008 SHALL have port FLUSH  input  1  pipeline flush from branch resolution.
REQ-009 SHALL have ports STK_FULL and STK_EMPTY  input  1 each  stack status flags.
REQ-010 SHALL have port STK_DATA  input  STK_WIDTH  stack read data, valid at the rising edge that ends a read-strobe cycle.
REQ-011 SHALL have port STK_WR  output  1  stack write strobe (drives the stack's POP input: writes STK_DIN and moves SP down).
REQ-012 SHALL have port STK_RD  output  1  stack read strobe (drives the stack's PUSH input: reads top entry and moves SP up).
REQ-013 SHALL have port STK_DIN  output  STK_WIDTH  data to write.
REQ-014 SHALL have ports PRED_VALID  output  1  and PRED_TARGET  output  STK_WIDTH  predicted return target.
REQ-015 SHALL have port NO_PRED  output  1  one-cycle pulse: return seen with the stack empty.
REQ-016 SHALL have port STALL  output  1  high whenever the FSM is not IDLE; decode holds its instruction.
REQ-017 SHALL have port OVF_CNT  output  8  count of calls dropped because the stack was full.

Function
REQ-018 SHALL implement FSM states IDLE, WR, RD, RSP, RSP_WR; all outputs SHALL be registered.
REQ-019 SHALL sample IS_CALL/IS_RET only in IDLE; requests while STALL=1 SHALL be ignored.
REQ-020 For IDLE with IS_CALL=1, IS_RET=0, STK_FULL=0: next state WR, STK_WR=1 for exactly one cycle, STK_DIN=PC_PLUS4 latched; then IDLE.
REQ-021 For IDLE with IS_CALL=1, STK_FULL=1: SHALL issue no write, increment OVF_CNT (saturating at 255), and remain IDLE.
REQ-022 For IDLE with IS_RET=1, STK_EMPTY=0: SHALL go to RD with STK_RD=1 for one cycle, capture STK_DATA at the end of RD, then enter RSP with PRED_VALID=1 and PRED_TARGET=captured value for one cycle, then IDLE. Latency request-to-PRED_VALID = 2 cycles.
REQ-023 For IDLE with IS_RET=1, STK_EMPTY=1: SHALL pulse NO_PRED for one cycle, issue no strobe, and remain IDLE.
REQ-024 When IS_CALL=1 and IS_RET=1 together, the pop SHALL go first: RD -> RSP_WR (PRED_VALID=1 and STK_WR=1 in the same cycle, STK_DIN=PC_PLUS4 latched at request) -> IDLE. An empty stack skips the pop: NO_PRED pulses and the write still proceeds.
REQ-025 STK_WR and STK_RD SHALL never be high in the same cycle.
REQ-026 FLUSH=1 SHALL force the next state to IDLE with STK_WR, STK_RD and PRED_VALID low next cycle; a strobe already driven in the flush cycle completes; FLUSH in RD SHALL suppress RSP.
REQ-027 PRED_TARGET SHALL hold its last value when PRED_VALID=0.

Reset
REQ-028 RST=0 at a rising edge SHALL force state IDLE and drive STK_WR, STK_RD, PRED_VALID, NO_PRED and STALL to 0, and STK_DIN, PRED_TARGET and OVF_CNT to 0; reset SHALL take priority over FLUSH and requests, and a strobe interrupted by reset is abandoned.

Structure
REQ-029 Package ras_pkg SHALL hold the FSM state encoding, the default widths STK_WIDTH and PTR_WIDTH, and OVF_CNT_W=8.
REQ-030 The saturating overflow counter SHALL be a sub-module sat_cnt (parameter width, inputs inc and clear).

Verification
REQ-031 Bench: call with PC_PLUS4=0x0040_0010, then return -> STK_WR for 1 cycle with STK_DIN=0x0040_0010; PRED_VALID 2 cycles after the return with PRED_TARGET=0x0040_0010.
REQ-032 Bench: return with STK_EMPTY=1 -> NO_PRED for 1 cycle, no strobes, STALL=0.
REQ-033 Bench: 300 calls with STK_FULL=1 -> OVF_CNT=255, no STK_WR.
REQ-034 Bench: IS_CALL and IS_RET together, top=0x100, PC_PLUS4=0x200 -> STK_RD cycle, then PRED_TARGET=0x100 with STK_WR and STK_DIN=0x200 in the same cycle.
REQ-035 Bench: FLUSH during RD -> no PRED_VALID, IDLE next cycle; a return the following cycle is accepted.
REQ-036 Bench: RST low during WR -> all outputs 0 on the next cycle and OVF_CNT cleared.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared definitions for the return-address-stack controller.
package ras_pkg;

    localparam int unsigned STK_WIDTH = 32;
    localparam int unsigned PTR_WIDTH = 6;
    localparam int unsigned OVF_CNT_W = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWr    = 3'd1,
        StRd    = 3'd2,
        StRsp   = 3'd3,
        StRspWr = 3'd4
    } ras_state_e;

endpackage

// File: rtl/ras_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: turns decode-stage calls/returns into
// strobes on an external stack and produces a registered return prediction.
module ras_ctrl #(
    parameter int unsigned STK_WIDTH = ras_pkg::STK_WIDTH,
    parameter int unsigned PTR_WIDTH = ras_pkg::PTR_WIDTH
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IS_CALL,
    input  logic                           IS_RET,
    input  logic [STK_WIDTH-1:0]           PC_PLUS4,
    input  logic                           FLUSH,
    input  logic                           STK_FULL,
    input  logic                           STK_EMPTY,
    input  logic [STK_WIDTH-1:0]           STK_DATA,
    output logic                           STK_WR,
    output logic                           STK_RD,
    output logic [STK_WIDTH-1:0]           STK_DIN,
    output logic                           PRED_VALID,
    output logic [STK_WIDTH-1:0]           PRED_TARGET,
    output logic                           NO_PRED,
    output logic                           STALL,
    output logic [ras_pkg::OVF_CNT_W-1:0]  OVF_CNT
);

    import ras_pkg::*;

    // The external stack must have at least two entries.
    if (PTR_WIDTH < 1) begin : g_ptr_width_check
        $error("ras_ctrl: PTR_WIDTH must be at least 1");
    end

    ras_state_e           state_q, state_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 pv_q, pv_d;
    logic                 nopred_q, nopred_d;
    logic                 stall_q, stall_d;
    logic                 call_pend_q, call_pend_d;  // RD was entered for a call+return pair
    logic [STK_WIDTH-1:0] din_q, din_d;
    logic [STK_WIDTH-1:0] tgt_q, tgt_d;
    logic                 ovf_inc;

    // Next-state and next-output decode; every output is the registered copy.
    always_comb begin
        state_d     = state_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        pv_d        = 1'b0;
        nopred_d    = 1'b0;
        call_pend_d = call_pend_q;
        din_d       = din_q;
        tgt_d       = tgt_q;
        ovf_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (IS_CALL && IS_RET) begin
                    // Pop first; the push follows in the response cycle.
                    din_d = PC_PLUS4;
                    if (STK_EMPTY) begin
                        nopred_d = 1'b1;
                        wr_d     = 1'b1;
                        state_d  = StWr;
                    end else begin
                        rd_d        = 1'b1;
                        call_pend_d = 1'b1;
                        state_d     = StRd;
                    end
                end else if (IS_CALL) begin
                    if (STK_FULL) begin
                        ovf_inc = 1'b1;
                    end else begin
                        din_d   = PC_PLUS4;
                        wr_d    = 1'b1;
                        state_d = StWr;
                    end
                end else if (IS_RET) begin
                    if (STK_EMPTY) begin
                        nopred_d = 1'b1;
                    end else begin
                        rd_d        = 1'b1;
                        call_pend_d = 1'b0;
                        state_d     = StRd;
                    end
                end
            end
            StRd: begin
                // STK_DATA is valid at the edge that ends the read cycle.
                tgt_d   = STK_DATA;
                pv_d    = 1'b1;
                wr_d    = call_pend_q;
                state_d = call_pend_q ? StRspWr : StRsp;
            end
            StWr, StRsp, StRspWr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A flush cancels whatever was about to start; the current strobe still completes.
        if (FLUSH) begin
            state_d  = StIdle;
            wr_d     = 1'b0;
            rd_d     = 1'b0;
            pv_d     = 1'b0;
            nopred_d = 1'b0;
            din_d    = din_q;
            tgt_d    = tgt_q;
            ovf_inc  = 1'b0;
        end

        stall_d = (state_d != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            pv_q        <= 1'b0;
            nopred_q    <= 1'b0;
            stall_q     <= 1'b0;
            call_pend_q <= 1'b0;
            din_q       <= '0;
            tgt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            pv_q        <= pv_d;
            nopred_q    <= nopred_d;
            stall_q     <= stall_d;
            call_pend_q <= call_pend_d;
            din_q       <= din_d;
            tgt_q       <= tgt_d;
        end
    end

    sat_cnt #(
        .WIDTH (OVF_CNT_W)
    ) u_ovf_cnt (
        .clk   (CLK),
        .inc   (ovf_inc),
        .clear (!RST),
        .count (OVF_CNT)
    );

    assign STK_WR      = wr_q;
    assign STK_RD      = rd_q;
    assign STK_DIN     = din_q;
    assign PRED_VALID  = pv_q;
    assign PRED_TARGET = tgt_q;
    assign NO_PRED     = nopred_q;
    assign STALL       = stall_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios followed by random
// traffic, checked every cycle against a transaction-schedule reference model.
module tb_ras_ctrl;

    localparam int unsigned DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RST, IS_CALL, IS_RET, FLUSH, STK_FULL, STK_EMPTY;
    logic [31:0] PC_PLUS4, STK_DATA;
    logic        STK_WR, STK_RD, PRED_VALID, NO_PRED, STALL;
    logic [31:0] STK_DIN, PRED_TARGET;
    logic [7:0]  OVF_CNT;

    always #5 CLK = ~CLK;

    ras_ctrl #(
        .STK_WIDTH (32),
        .PTR_WIDTH (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IS_CALL     (IS_CALL),
        .IS_RET      (IS_RET),
        .PC_PLUS4    (PC_PLUS4),
        .FLUSH       (FLUSH),
        .STK_FULL    (STK_FULL),
        .STK_EMPTY   (STK_EMPTY),
        .STK_DATA    (STK_DATA),
        .STK_WR      (STK_WR),
        .STK_RD      (STK_RD),
        .STK_DIN     (STK_DIN),
        .PRED_VALID  (PRED_VALID),
        .PRED_TARGET (PRED_TARGET),
        .NO_PRED     (NO_PRED),
        .STALL       (STALL),
        .OVF_CNT     (OVF_CNT)
    );

    // Expected output snapshot for one cycle.
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        pv;
        logic        nopred;
        logic        stall;
        logic [31:0] din;
        logic [31:0] tgt;
    } exp_t;

    exp_t        cur = '0;   // outputs expected after the most recent edge
    exp_t        pend[$];    // outputs scheduled for the following edges
    int unsigned m_ovf = 0;

    // External stack emulation; shares the controller's reset.
    logic [31:0] stk [DEPTH];
    int unsigned cnt = 0;
    logic        force_full = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a request accepted while idle schedules its whole output sequence.
    task automatic model_edge();
        exp_t nxt;
        exp_t e;
        nxt        = cur;
        nxt.wr     = 1'b0;
        nxt.rd     = 1'b0;
        nxt.pv     = 1'b0;
        nxt.nopred = 1'b0;
        nxt.stall  = 1'b0;
        if (!RST) begin
            nxt   = '0;
            pend.delete();
            m_ovf = 0;
        end else if (FLUSH) begin
            pend.delete();
        end else if (pend.size() > 0) begin
            nxt = pend.pop_front();
        end else if (!cur.stall) begin
            if (IS_CALL && IS_RET) begin
                nxt.din = PC_PLUS4;
                if (STK_EMPTY) begin
                    nxt.nopred = 1'b1;
                    nxt.wr     = 1'b1;
                    nxt.stall  = 1'b1;
                end else begin
                    nxt.rd    = 1'b1;
                    nxt.stall = 1'b1;
                    e         = nxt;
                    e.rd      = 1'b0;
                    e.pv      = 1'b1;
                    e.wr      = 1'b1;
                    e.tgt     = STK_DATA;
                    pend.push_back(e);
                end
            end else if (IS_CALL) begin
                if (STK_FULL) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    nxt.wr    = 1'b1;
                    nxt.din   = PC_PLUS4;
                    nxt.stall = 1'b1;
                end
            end else if (IS_RET) begin
                if (STK_EMPTY) begin
                    nxt.nopred = 1'b1;
                end else begin
                    nxt.rd    = 1'b1;
                    nxt.stall = 1'b1;
                    e         = nxt;
                    e.rd      = 1'b0;
                    e.pv      = 1'b1;
                    e.tgt     = STK_DATA;
                    pend.push_back(e);
                end
            end
        end
        cur = nxt;
    endtask

    task automatic compare_all();
        check_eq("stk_wr", STK_WR, cur.wr);
        check_eq("stk_rd", STK_RD, cur.rd);
        check_eq("stk_din", STK_DIN, cur.din);
        check_eq("pred_valid", PRED_VALID, cur.pv);
        check_eq("pred_target", PRED_TARGET, cur.tgt);
        check_eq("no_pred", NO_PRED, cur.nopred);
        check_eq("stall", STALL, cur.stall);
        check_eq("ovf_cnt", OVF_CNT, m_ovf);
        check_eq("wr_rd_excl", STK_WR & STK_RD, 1'b0);
    endtask

    // One clock: called just after a falling edge with the request inputs set.
    task automatic step();
        logic [31:0] top;
        top       = (cnt > 0) ? stk[cnt-1] : 32'hdead_beef;
        STK_FULL  = (cnt == DEPTH) || force_full;
        STK_EMPTY = (cnt == 0);
        STK_DATA  = top;
        model_edge();
        if (!RST) begin
            cnt = 0;
        end else begin
            if (STK_RD === 1'b1 && cnt > 0) cnt--;
            if (STK_WR === 1'b1 && cnt < DEPTH) begin
                stk[cnt] = STK_DIN;
                cnt++;
            end
        end
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    task automatic cyc(input logic c, input logic r, input logic f, input logic [31:0] pc);
        IS_CALL  = c;
        IS_RET   = r;
        FLUSH    = f;
        PC_PLUS4 = pc;
        step();
    endtask

    initial begin
        RST      = 1'b0;
        IS_CALL  = 1'b0;
        IS_RET   = 1'b0;
        FLUSH    = 1'b0;
        PC_PLUS4 = '0;
        @(negedge CLK);
        step();
        step();
        check_eq("reset_ovf", OVF_CNT, 0);
        check_eq("reset_stall", STALL, 0);
        RST = 1'b1;

        // Call then return.
        cyc(1'b1, 1'b0, 1'b0, 32'h0040_0010);
        check_eq("call_wr", STK_WR, 1'b1);
        check_eq("call_din", STK_DIN, 32'h0040_0010);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("call_wr_one_cycle", STK_WR, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("ret_rd", STK_RD, 1'b1);
        check_eq("ret_pv_not_yet", PRED_VALID, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("ret_pv", PRED_VALID, 1'b1);
        check_eq("ret_tgt", PRED_TARGET, 32'h0040_0010);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("ret_pv_one_cycle", PRED_VALID, 1'b0);
        check_eq("ret_tgt_hold", PRED_TARGET, 32'h0040_0010);

        // Return on an empty stack.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("empty_nopred", NO_PRED, 1'b1);
        check_eq("empty_no_rd", STK_RD, 1'b0);
        check_eq("empty_no_stall", STALL, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("empty_nopred_pulse", NO_PRED, 1'b0);

        // Simultaneous call and return with top = 0x100.
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h200);
        check_eq("both_rd", STK_RD, 1'b1);
        check_eq("both_no_wr_yet", STK_WR, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("both_pv", PRED_VALID, 1'b1);
        check_eq("both_tgt", PRED_TARGET, 32'h100);
        check_eq("both_wr", STK_WR, 1'b1);
        check_eq("both_din", STK_DIN, 32'h200);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Flush during RD, then a return the very next cycle.
        cyc(1'b1, 1'b0, 1'b0, 32'h300);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("flush_rd_issued", STK_RD, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("flush_no_pv", PRED_VALID, 1'b0);
        check_eq("flush_idle", STALL, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("post_flush_rd", STK_RD, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("post_flush_tgt", PRED_TARGET, 32'h200);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Overflow counting saturates.
        force_full = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0, 1'b0, $urandom);
        end
        check_eq("ovf_saturated", OVF_CNT, 8'd255);
        force_full = 1'b0;

        // Reset while a write is in flight.
        cyc(1'b1, 1'b0, 1'b0, 32'h55);
        check_eq("pre_reset_wr", STK_WR, 1'b1);
        RST = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 32'h77);
        check_eq("rst_wr", STK_WR, 1'b0);
        check_eq("rst_din", STK_DIN, 32'h0);
        check_eq("rst_ovf", OVF_CNT, 8'd0);
        RST = 1'b1;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            RST        = ($urandom_range(0, 99) != 0);
            force_full = ($urandom_range(0, 9) == 0);
            cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
